// File: rtl/lis_pkg.sv
// Shared definitions for the LIS sorter stream adapters: symbol/word geometry
// and the packer control states.
package lis_pkg;

  localparam int LIS_BYTE_W     = 8;
  localparam int LIS_DATA_BYTES = 4;
  localparam int LIS_WORD_W     = LIS_BYTE_W * LIS_DATA_BYTES;
  localparam int LIS_CNT_W      = 16;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } pack_state_e;

endpackage

// File: rtl/lis_byte_packer.sv
// Packs the 8-bit ready/valid/last pin stream into DATA_BYTES-wide words, first
// byte in the MSB, with a one-word output register so bytes keep flowing while the sorter stalls.
module lis_byte_packer
  import lis_pkg::*;
#(
  parameter int BYTE_W     = LIS_BYTE_W,
  parameter int DATA_BYTES = LIS_DATA_BYTES,
  parameter int CNT_W      = LIS_CNT_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BYTE_W-1:0]            in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BYTE_W*DATA_BYTES-1:0] out_data,
  output logic                         out_last,
  output logic                         err_partial,
  output logic [CNT_W-1:0]             words_out
);

  localparam int WORD_W = BYTE_W * DATA_BYTES;
  localparam int IDX_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

  pack_state_e        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic [WORD_W-1:0]  out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   words_q, words_d;

  logic               out_free;
  logic               accept;
  logic [WORD_W-1:0]  merged;

  assign out_free = !out_valid_q || out_ready;

  // Accumulator with the incoming byte dropped into slot idx. Lower slots are
  // always zero here because acc is cleared whenever a word leaves it.
  always_comb begin
    merged = acc_q;
    for (int s = 0; s < DATA_BYTES; s++) begin
      if (idx_q == IDX_W'(s)) begin
        merged[WORD_W - BYTE_W*(s+1) +: BYTE_W] = in_data;
      end
    end
  end

  // NOTE: every signal driven here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    words_d     = words_q;
    in_ready    = 1'b0;
    accept      = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      words_d     = words_q + CNT_W'(1);
    end

    unique case (state_q)
      FILL: begin
        // Only the word-completing byte needs room in the output register.
        in_ready = (idx_q != LAST_IDX) || out_free;
        accept   = in_valid && in_ready;
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            out_data_d  = merged;
            out_last_d  = in_last;
            out_valid_d = 1'b1;
            acc_d       = '0;
            idx_d       = '0;
          end else if (in_last) begin
            err_d = 1'b1;
            idx_d = '0;
            if (out_free) begin
              out_data_d  = merged;
              out_last_d  = 1'b1;
              out_valid_d = 1'b1;
              acc_d       = '0;
            end else begin
              acc_d   = merged;
              state_d = STALL;
            end
          end else begin
            acc_d = merged;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      STALL: begin
        if (out_free) begin
          out_data_d  = acc_q;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
          acc_d       = '0;
          state_d     = FILL;
        end
      end

      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value. The accumulator is reset too, since short frames rely on
  // its unused low slots reading as zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      idx_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      words_q     <= words_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign out_valid   = out_valid_q;
  assign err_partial = err_q;
  assign words_out   = words_q;

endmodule
